// File: rtl/complex_mult_arbiter.sv
// complex_mult_arbiter: round-robin sharing of one complex multiplier between NUM_REQ requesters
module complex_mult_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 17,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int TIMEOUT    = 64
)(
    input  logic                            i_clk,
    input  logic                            i_sw_rst,
    input  logic [NUM_REQ-1:0]              i_req_val,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ*4*DATA_WIDTH-1:0] i_req_op,
    output logic [NUM_REQ-1:0]              o_rsp_val,
    input  logic [NUM_REQ-1:0]              i_rsp_ready,
    output logic [RES_WIDTH-1:0]            o_rsp_re,
    output logic [RES_WIDTH-1:0]            o_rsp_im,
    output logic                            o_rsp_err,
    output logic                            o_op_val,
    input  logic                            i_op_ready,
    output logic [DATA_WIDTH-1:0]           o_op_1_re,
    output logic [DATA_WIDTH-1:0]           o_op_1_im,
    output logic [DATA_WIDTH-1:0]           o_op_2_re,
    output logic [DATA_WIDTH-1:0]           o_op_2_im,
    input  logic                            i_res_val,
    output logic                            o_res_ready,
    input  logic [RES_WIDTH-1:0]            i_res_re,
    input  logic [RES_WIDTH-1:0]            i_res_im,
    output logic                            o_busy,
    output logic [ID_WIDTH-1:0]             o_owner_id,
    output logic                            o_timeout_err
);
    localparam int OW = 4 * DATA_WIDTH;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t                 r_state, w_next;
    logic [ID_WIDTH-1:0]    r_ptr, r_owner, w_gnt;
    logic [ID_WIDTH:0]      w_sum;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic                   w_found, w_to, w_acc;
    logic [OW-1:0]          r_ops;
    logic [WW-1:0]          r_wd;
    logic [RES_WIDTH-1:0]   r_re, r_im;
    logic                   r_err, r_terr;

    // first requesting index at or after the pointer, wrapping around
    always_comb begin
        w_dbl   = {i_req_val, i_req_val} >> r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (ID_WIDTH+1)'(k);
            end
        end
        w_gnt = (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) ? ID_WIDTH'(w_sum - (ID_WIDTH+1)'(NUM_REQ)) : w_sum[ID_WIDTH-1:0];
    end

    assign w_to          = (TIMEOUT != 0) && (r_wd == WW'(TIMEOUT - 1));
    assign w_acc         = |(i_rsp_ready & o_rsp_val);
    assign o_req_ready   = (r_state == S_IDLE && w_found) ? NUM_REQ'(1) << w_gnt : '0;
    assign o_rsp_val     = (r_state == S_DELIVER) ? NUM_REQ'(1) << r_owner : '0;
    assign o_op_val      = (r_state == S_ISSUE);
    assign o_res_ready   = (r_state == S_WAIT);
    assign o_busy        = (r_state != S_IDLE);
    assign o_owner_id    = (r_state == S_IDLE) ? '0 : r_owner;
    assign o_rsp_re      = r_re;
    assign o_rsp_im      = r_im;
    assign o_rsp_err     = r_err;
    assign o_timeout_err = r_terr;
    assign {o_op_2_im, o_op_2_re, o_op_1_im, o_op_1_re} = r_ops;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_sw_rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state: grant, issue, wait for result or watchdog, deliver
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_found ? S_ISSUE : S_IDLE;
            S_ISSUE:   w_next = i_op_ready ? S_WAIT : S_ISSUE;
            S_WAIT:    w_next = (i_res_val || w_to) ? S_DELIVER : S_WAIT;
            S_DELIVER: w_next = w_acc ? S_IDLE : S_DELIVER;
            default:   w_next = S_IDLE;
        endcase
    end

    // operand latch, watchdog, result capture and pointer advance
    always_ff @(posedge i_clk) begin
        if (i_sw_rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_ops   <= '0;
            r_wd    <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_err   <= 1'b0;
            r_terr  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_ops   <= i_req_op[w_gnt*OW +: OW];
                r_owner <= w_gnt;
            end
        end else if (r_state == S_ISSUE) begin
            if (i_op_ready) r_wd <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd <= r_wd + WW'(1);
            if (i_res_val) begin
                r_re  <= i_res_re;
                r_im  <= i_res_im;
                r_err <= 1'b0;
            end else if (w_to) begin
                r_re   <= '0;
                r_im   <= '0;
                r_err  <= 1'b1;
                r_terr <= 1'b1;
            end
        end else if (w_acc) begin
            r_ptr <= (r_owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_owner + ID_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_complex_mult_arbiter.sv
// tb_complex_mult_arbiter: directed and randomized transactions against a round-robin reference model
module tb_complex_mult_arbiter;
    localparam int DW = 8;
    localparam int RW = 17;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sw_rst;
    logic [N-1:0]      req_val, req_ready, rsp_val, rsp_ready;
    logic [N*4*DW-1:0] req_op;
    logic [RW-1:0]     rsp_re, rsp_im, res_re, res_im;
    logic              rsp_err, op_val, op_ready, res_val, res_ready, busy, timeout_err;
    logic [DW-1:0]     o1r, o1i, o2r, o2i;
    logic [IW-1:0]     owner_id;

    logic [4*DW-1:0] ops [N];
    int n_chk, n_err, ptr, e;
    bit exp_terr, in_dlv, bad_rdy, bad_rsp;

    complex_mult_arbiter #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .NUM_REQ(N), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_sw_rst(sw_rst), .i_req_val(req_val), .o_req_ready(req_ready), .i_req_op(req_op),
        .o_rsp_val(rsp_val), .i_rsp_ready(rsp_ready), .o_rsp_re(rsp_re), .o_rsp_im(rsp_im), .o_rsp_err(rsp_err),
        .o_op_val(op_val), .i_op_ready(op_ready), .o_op_1_re(o1r), .o_op_1_im(o1i), .o_op_2_re(o2r), .o_op_2_im(o2i),
        .i_res_val(res_val), .o_res_ready(res_ready), .i_res_re(res_re), .i_res_im(res_im),
        .o_busy(busy), .o_owner_id(owner_id), .o_timeout_err(timeout_err)
    );

    // complex product of {op_2_im, op_2_re, op_1_im, op_1_re}, signed parts, returned as {im, re}
    function automatic logic [2*RW-1:0] cmul(input logic [4*DW-1:0] op);
        int a, b, c, d, re, im;
        a  = int'($signed(op[DW-1:0]));
        b  = int'($signed(op[2*DW-1:DW]));
        c  = int'($signed(op[3*DW-1:2*DW]));
        d  = int'($signed(op[4*DW-1:3*DW]));
        re = a * c - b * d;
        im = a * d + b * c;
        return {RW'(im), RW'(re)};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) req_op[i*4*DW +: 4*DW] = ops[i];
    endtask

    task automatic newop(input int i);
        ops[i] = $urandom;
        pack();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (busy === 1'b1 && req_ready !== '0) bad_rdy = 1'b1;
        if (!in_dlv && rsp_val !== '0) bad_rsp = 1'b1;
    endtask

    task automatic do_reset();
        sw_rst = 1'b1;
        cyc();
        cyc();
        sw_rst   = 1'b0;
        ptr      = 0;
        exp_terr = 1'b0;
    endtask

    task automatic run_one(input int exp_o, input int opw, input int lat, input int rspw, input bit to, input bit drop);
        logic [4*DW-1:0] eop;
        logic [2*RW-1:0] er, mr;
        logic [N-1:0]    oh;
        oh = N'(1) << exp_o;
        #1;
        chk("grant", 64'(req_ready), 64'(oh));
        eop = ops[exp_o];
        er  = to ? '0 : cmul(eop);
        rsp_ready = (rspw == 0) ? '1 : ~oh;
        cyc();
        if (drop) req_val[exp_o] = 1'b0;
        newop(exp_o);
        chk("op_val", 64'(op_val), 64'(1));
        chk("owner", 64'(owner_id), 64'(exp_o));
        chk("operands", 64'({o2i, o2r, o1i, o1r}), 64'(eop));
        chk("busy", 64'(busy), 64'(1));
        repeat (opw) begin
            cyc();
            chk("op_hold", 64'({op_val, o2i, o2r, o1i, o1r}), 64'({1'b1, eop}));
        end
        mr = cmul({o2i, o2r, o1i, o1r});
        op_ready = 1'b1;
        cyc();
        op_ready = 1'b0;
        chk("res_ready", 64'({op_val, res_ready}), 64'(1));
        if (to) begin
            repeat (TO - 1) cyc();
            chk("still_wait", 64'({res_ready, rsp_val}), 64'({1'b1, 4'b0}));
            in_dlv = 1'b1;
            cyc();
            exp_terr = 1'b1;
        end else begin
            repeat (lat - 1) cyc();
            res_val = 1'b1;
            {res_im, res_re} = mr;
            in_dlv = 1'b1;
            cyc();
            res_val = 1'b0;
            res_re  = RW'($urandom);
            res_im  = RW'($urandom);
        end
        chk("rsp_val", 64'(rsp_val), 64'(oh));
        chk("rsp_data", 64'({rsp_im, rsp_re}), 64'(er));
        chk("rsp_err", 64'(rsp_err), 64'(to));
        chk("timeout_err", 64'(timeout_err), 64'(exp_terr));
        chk("res_ready_off", 64'(res_ready), 64'(0));
        repeat (rspw) begin
            cyc();
            chk("rsp_hold", 64'({rsp_val, rsp_im, rsp_re}), 64'({oh, er}));
        end
        rsp_ready = '1;
        cyc();
        in_dlv = 1'b0;
        chk("idle", 64'({busy, rsp_val, owner_id}), 64'(0));
        ptr = (exp_o + 1) % N;
        chk("no_ready_busy", 64'(bad_rdy), 64'(0));
        chk("no_rsp_outside", 64'(bad_rsp), 64'(0));
        bad_rdy = 1'b0;
        bad_rsp = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_chk = 0; n_err = 0; in_dlv = 0; bad_rdy = 0; bad_rsp = 0;
        sw_rst = 0; req_val = '0; rsp_ready = '0; op_ready = 0; res_val = 0; res_re = '0; res_im = '0;
        for (int i = 0; i < N; i++) ops[i] = $urandom;
        ops[0] = {8'd2, 8'd4, 8'd3, 8'd2};
        pack();
        do_reset();
        chk("reset_a", 64'({req_ready, rsp_val, rsp_re, rsp_im, rsp_err, op_val}), 64'(0));
        chk("reset_b", 64'({o1r, o1i, o2r, o2i, res_ready, busy, owner_id, timeout_err}), 64'(0));
        // single request with a fixed operand set
        req_val = 4'b0001;
        run_one(0, 0, 5, 0, 0, 1);
        // all requesting, round-robin from a fresh pointer
        do_reset();
        req_val = 4'b1111;
        for (int g = 0; g < N; g++) begin
            e = pick(req_val, ptr);
            chk("rr_order", 64'(e), 64'(g));
            run_one(e, 0, int'($urandom_range(1, 4)), 0, 0, 0);
        end
        req_val = '0;
        cyc();
        // pointer wrap after requester 3
        req_val = 4'b1001;
        run_one(pick(req_val, ptr), 0, 2, 0, 0, 1);
        run_one(pick(req_val, ptr), 1, 3, 1, 0, 1);
        // operand and response backpressure with another requester pending
        req_val = 4'b0110;
        run_one(pick(req_val, ptr), 5, int'($urandom_range(1, 6)), 4, 0, 1);
        run_one(pick(req_val, ptr), 0, 1, 0, 0, 1);
        // watchdog expiry, then a clean result with the sticky flag still set
        req_val = 4'b0001;
        run_one(pick(req_val, ptr), 0, 0, 2, 1, 1);
        req_val = 4'b1000;
        run_one(pick(req_val, ptr), 0, 3, 0, 0, 1);
        // randomized traffic
        repeat (8) begin
            req_val = N'($urandom_range(1, 15));
            run_one(pick(req_val, ptr), int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), 0, 0);
            req_val = '0;
        end
        // reset while waiting for a result
        req_val = 4'b0100;
        e = pick(req_val, ptr);
        #1;
        chk("t6_grant", 64'(req_ready), 64'(N'(1) << e));
        cyc();
        req_val = '0;
        op_ready = 1'b1;
        cyc();
        op_ready = 1'b0;
        cyc();
        chk("t6_wait", 64'(res_ready), 64'(1));
        sw_rst = 1'b1;
        cyc();
        sw_rst = 1'b0;
        chk("t6_zero_a", 64'({req_ready, rsp_val, rsp_re, rsp_im, rsp_err, op_val}), 64'(0));
        chk("t6_zero_b", 64'({o1r, o1i, o2r, o2i, res_ready, busy, owner_id, timeout_err}), 64'(0));
        ptr = 0;
        exp_terr = 1'b0;
        cyc();
        cyc();
        chk("t6_no_rsp", 64'({rsp_val, busy}), 64'(0));
        req_val = 4'b1010;
        e = pick(req_val, ptr);
        chk("t6_ptr0", 64'(e), 64'(1));
        run_one(e, 0, 2, 0, 0, 1);
        req_val = '0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
